multiport_inst_buffer: RTL

MULTIPORT_INST_BUFFER -- requirements
Module: multiport_inst_buffer

---
 rtl/multiport_inst_buffer.sv | 116 +++++++++++
 1 files changed

// File: rtl/multiport_inst_buffer.sv
// Multi-port instruction buffer: circular FIFO between fetch and decode.
// Accepts up to ENQ_W packets per cycle (holes in the valid mask are compacted)
// and presents up to DEQ_W oldest entries per cycle, fall-through (no read latency).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop all buffered entries (overrides enqueue/dequeue)
//   enq_valid/enq_data    per-lane enqueue mask and payloads (lane i at [i*PKT_W +: PKT_W])
//   enq_ready             room for a full ENQ_W group, from registered count only
//   deq_valid/deq_data    head-aligned view, oldest in lane 0, zeros on invalid lanes
//   deq_num               entries consumed this cycle (clamped to count and DEQ_W)
//   count/full/empty      occupancy status
module multiport_inst_buffer #(
    parameter int unsigned PKT_W = 64,
    parameter int unsigned ENQ_W = 2,
    parameter int unsigned DEQ_W = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [ENQ_W-1:0]           enq_valid,
    input  logic [ENQ_W*PKT_W-1:0]     enq_data,
    output logic                       enq_ready,
    output logic [DEQ_W-1:0]           deq_valid,
    output logic [DEQ_W*PKT_W-1:0]     deq_data,
    input  logic [$clog2(DEQ_W+1)-1:0] deq_num,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned EN_W  = $clog2(ENQ_W + 1);
    localparam int unsigned DN_W  = $clog2(DEQ_W + 1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Storage is deliberately not reset: lanes beyond count are forced to zero.
    logic [PKT_W-1:0] mem_q [DEPTH];

    logic [EN_W-1:0]  enq_cnt;
    logic [DN_W-1:0]  deq_cl;
    logic [ENQ_W-1:0] wr_en;
    logic [PTR_W-1:0] wr_idx [ENQ_W];

    // Full-group admission only, so a set of lanes either all land or none do.
    assign enq_ready = (32'(count_q) + ENQ_W) <= DEPTH;

    // Compact the valid lanes: each set lane goes to tail + (number of set lanes below it).
    always_comb begin
        enq_cnt = '0;
        for (int i = 0; i < int'(ENQ_W); i++) begin
            wr_en[i]  = 1'b0;
            wr_idx[i] = '0;
            if (enq_ready && !flush && enq_valid[i]) begin
                wr_en[i]  = 1'b1;
                wr_idx[i] = tail_q + PTR_W'(enq_cnt);
                enq_cnt   = enq_cnt + EN_W'(1);
            end
        end
    end

    // Dequeue amount limited by occupancy and lane count.
    always_comb begin
        deq_cl = deq_num;
        if (32'(deq_cl) > 32'(count_q)) deq_cl = DN_W'(count_q);
        if (32'(deq_cl) > DEQ_W)        deq_cl = DN_W'(DEQ_W);
    end

    always_comb begin
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Power-of-two depth: pointer wrap is plain truncation.
            head_d  = head_q + PTR_W'(deq_cl);
            tail_d  = tail_q + PTR_W'(enq_cnt);
            count_d = count_q + CNT_W'(enq_cnt) - CNT_W'(deq_cl);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(ENQ_W); i++) begin
            if (wr_en[i]) mem_q[wr_idx[i]] <= enq_data[i*PKT_W +: PKT_W];
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEQ_W); i++) begin
            deq_valid[i] = int'(count_q) > i;
            deq_data[i*PKT_W +: PKT_W] = deq_valid[i] ? mem_q[head_q + PTR_W'(i)] : '0;
        end
    end

    assign count = count_q;
    assign full  = (32'(count_q) == DEPTH);
    assign empty = (count_q == '0);

endmodule
